// File: rtl/noc_inject.sv
// noc_inject: local injection stage for the 4-router ring NoC.
// Queues PE requests, builds flits, paces injection against ring backpressure.
module noc_inject #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDWIDTH = 2,
  parameter int unsigned SRC_ID   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_dest,
  input  logic [WIDTH-3:0]    in_payload,
  input  logic                full,
  input  logic                almost_full,
  output logic                write,
  output logic [WIDTH-1:0]    dataOut,
  output logic                err_self,
  output logic [ADDWIDTH:0]   count,
  output logic [15:0]         sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDWIDTH-1:0]   rd_q, wr_q;
  logic [ADDWIDTH:0]     count_q, count_d;
  logic                  rdy_q;
  logic                  write_q;
  logic [WIDTH-1:0]      data_q;
  logic                  err_q;
  logic [15:0]           sent_q;

  logic accept, self_hit, push, issue;

  assign accept   = in_valid && rdy_q;
  assign self_hit = (in_dest == 2'(SRC_ID));
  assign push     = accept && !self_hit;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    count_d = count_q;
    unique case (state_q)
      IDLE, SEND: begin
        if (count_q != '0 && !full) begin
          issue = 1'b1;
        end
      end
      default: ;
    endcase
    unique case ({push, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // HOLD always spans at least one cycle so the flag lag is covered
    unique case (state_q)
      IDLE, SEND: begin
        if (issue) begin
          if (almost_full)        state_d = HOLD;
          else if (count_d != '0) state_d = SEND;
          else                    state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (!almost_full && !full) begin
          state_d = (count_q != '0) ? SEND : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {in_dest, in_payload};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      rdy_q   <= 1'b1;
      write_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdy_q   <= (count_d != (ADDWIDTH+1)'(DEPTH));
      write_q <= issue;
      err_q   <= accept && self_hit;
      if (push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (issue) begin
        data_q <= mem_q[rd_q];
        rd_q   <= rd_q + 1'b1;
        sent_q <= sent_q + 16'd1;
      end
    end
  end

  assign in_ready = rdy_q;
  assign write    = write_q;
  assign dataOut  = data_q;
  assign err_self = err_q;
  assign count    = count_q;
  assign sent     = sent_q;

endmodule

// File: tb/tb_noc_inject.sv
// tb_noc_inject: directed self-checking bench for noc_inject.
// Instance uses SRC_ID=3 so dest 3 exercises the self-drop path.
module tb_noc_inject;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_dest;
  logic [13:0] in_payload;
  logic        full;
  logic        almost_full;
  logic        write;
  logic [15:0] dataOut;
  logic        err_self;
  logic [2:0]  count;
  logic [15:0] sent;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] obs [$];
  int          ocyc [$];

  noc_inject #(
    .WIDTH(16), .DEPTH(4), .ADDWIDTH(2), .SRC_ID(3)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_dest(in_dest),
    .in_payload(in_payload),
    .full(full),
    .almost_full(almost_full),
    .write(write),
    .dataOut(dataOut),
    .err_self(err_self),
    .count(count),
    .sent(sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (write) begin
      obs.push_back(dataOut);
      ocyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic req(input logic [1:0] d, input logic [13:0] p);
    in_valid   = 1'b1;
    in_dest    = d;
    in_payload = p;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic clr();
    obs.delete();
    ocyc.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_dest = '0; in_payload = '0;
    full = 1'b0; almost_full = 1'b0;
    step(2);
    chk("rst_ready", in_ready, 1);
    chk("rst_write", write, 0);
    chk("rst_data", dataOut, 0);
    chk("rst_err", err_self, 0);
    chk("rst_count", count, 0);
    chk("rst_sent", sent, 0);
    rst_n = 1'b1;
    step();

    // single request, two-cycle latency
    clr();
    req(2'd2, 14'h0123);
    chk("t1_count1", count, 1);
    chk("t1_nowrite", write, 0);
    step();
    chk("t1_write", write, 1);
    chk("t1_data", dataOut, 16'h8123);
    chk("t1_sent", sent, 1);
    chk("t1_count0", count, 0);
    step();
    chk("t1_wr_off", write, 0);
    chk("t1_hold", dataOut, 16'h8123);

    // back-to-back stream
    clr();
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_dest = 2'd1; in_payload = 14'(k);
      step();
    end
    in_valid = 1'b0;
    step(4);
    chk("t2_n", obs.size(), 4);
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      chk("t2_flit", obs[i], 32'h4001 + i);
      chk("t2_gap", ocyc[i], ocyc[0] + i);
    end

    // full blocks issue, queue fills
    clr();
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_dest = 2'd2; in_payload = 14'(16 + k);
      step();
      if (k == 3) begin
        chk("t3_cnt4", count, 4);
        chk("t3_nrdy", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    chk("t3_cnt5", count, 4);
    chk("t3_nowr", obs.size(), 0);
    full = 1'b0;
    step(6);
    chk("t3_n", obs.size(), 4);
    for (int i = 0; i < obs.size() && i < 4; i++)
      chk("t3_flit", obs[i], 32'h8010 + i);
    chk("t3_rdy", in_ready, 1);
    chk("t3_cnt0", count, 0);

    // almost_full: one flit then hold
    full = 1'b1;
    for (int k = 1; k <= 3; k++) req(2'd1, 14'(32 + k));
    almost_full = 1'b1;
    full = 1'b0;
    clr();
    step(5);
    chk("t4_one", obs.size(), 1);
    if (obs.size() > 0) chk("t4_f0", obs[0], 16'h4021);
    chk("t4_cnt", count, 2);
    chk("t4_state", dut.state_q, 2);
    almost_full = 1'b0;
    step(6);
    chk("t4_n", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("t4_f1", obs[1], 16'h4022);
      chk("t4_f2", obs[2], 16'h4023);
      chk("t4_gap", ocyc[2], ocyc[1] + 1);
    end

    // self-addressed drop
    clr();
    req(2'd3, 14'h0055);
    chk("t5_err", err_self, 1);
    chk("t5_cnt", count, 0);
    step();
    chk("t5_err0", err_self, 0);
    step(3);
    chk("t5_nowr", obs.size(), 0);

    // sent wraps
    chk("t6_pre", sent, 12);
    in_valid = 1'b1; in_dest = 2'd0; in_payload = 14'h0007;
    step(65535 - 12);
    in_valid = 1'b0;
    step(4);
    chk("t6_ffff", sent, 16'hFFFF);
    chk("t6_cnt", count, 0);
    req(2'd0, 14'h0001);
    step(4);
    chk("t6_wrap", sent, 0);

    // reset flushes queue
    full = 1'b1;
    for (int k = 0; k < 3; k++) req(2'd1, 14'(k));
    chk("t7_cnt3", count, 3);
    rst_n = 1'b0;
    step();
    chk("t7_cnt0", count, 0);
    chk("t7_wr", write, 0);
    chk("t7_rdy", in_ready, 1);
    rst_n = 1'b1;
    full = 1'b0;
    clr();
    step(5);
    chk("t7_nowr", obs.size(), 0);
    chk("t7_sent", sent, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
